// File: rtl/alu_share_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: NOP field values,
// result-owner encoding and the per-stage tag carried alongside the ALU.
package alu_share_arb_pkg;

    localparam logic [2:0] FUNCT3_ADD  = 3'b000;
    localparam logic [6:0] FUNCT7_ZERO = 7'b000_0000;
    localparam logic       NOP_IMM     = 1'b1;

    typedef enum logic {
        OWN_PIPE = 1'b0,
        OWN_AUX  = 1'b1
    } owner_e;

    typedef struct packed {
        logic   v;
        owner_e owner;
    } tag_t;

    localparam tag_t TAG_EMPTY = '{v: 1'b0, owner: OWN_PIPE};

endpackage

// File: rtl/alu_share_arb_tag_pipe.sv
// Valid/owner shift register that travels in lockstep with the ALU so each
// result can be routed back to whichever requester issued it.
module alu_tag_pipe
    import alu_share_arb_pkg::*;
#(
    parameter int ALU_LAT = 1
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic i_flush,
    input  tag_t i_tag,
    output tag_t o_tail
);

    tag_t r_stage [ALU_LAT];

    // NOTE: every stage is reset because a stale v bit would fabricate a
    // response; a pure data delay line would not need a reset at all.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < ALU_LAT; i++) r_stage[i] <= TAG_EMPTY;
        end else if (i_flush) begin
            for (int i = 0; i < ALU_LAT; i++) r_stage[i] <= TAG_EMPTY;
        end else begin
            // NOTE: non-blocking assignments let all stages shift off the
            // same pre-edge values regardless of statement order.
            r_stage[0] <= i_tag;
            for (int i = 1; i < ALU_LAT; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_tail = r_stage[ALU_LAT-1];

endmodule

// File: rtl/alu_share_arb.sv
// Shares one registered ALU between the integer pipe (req0, fixed priority)
// and an auxiliary unit (req1) that is guaranteed a grant after MAX_WAIT stalls.
module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter int ALU_LAT  = 1,
    parameter int XLEN     = 64,
    parameter int MAX_WAIT = 4
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            flush,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic            req0_imm,
    input  logic [2:0]      req0_funct3,
    input  logic [6:0]      req0_funct7,
    input  logic [4:0]      req0_rd,
    input  logic            req0_wb,
    input  logic [XLEN-1:0] req0_op1,
    input  logic [XLEN-1:0] req0_op2,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic            req1_imm,
    input  logic [2:0]      req1_funct3,
    input  logic [6:0]      req1_funct7,
    input  logic [4:0]      req1_rd,
    input  logic            req1_wb,
    input  logic [XLEN-1:0] req1_op1,
    input  logic [XLEN-1:0] req1_op2,

    output logic            alu_imm,
    output logic [2:0]      alu_funct3,
    output logic [6:0]      alu_funct7,
    output logic [4:0]      alu_rd,
    output logic            alu_wb,
    output logic [XLEN-1:0] alu_op1,
    output logic [XLEN-1:0] alu_op2,

    input  logic [XLEN-1:0] alu_res,
    input  logic [4:0]      alu_rd_o,
    input  logic            alu_wb_en,

    output logic            rsp0_valid,
    output logic [XLEN-1:0] rsp0_res,
    output logic [4:0]      rsp0_rd,
    output logic            rsp0_wb,

    output logic            rsp1_valid,
    output logic [XLEN-1:0] rsp1_res,
    output logic [4:0]      rsp1_rd,
    output logic            rsp1_wb
);

    localparam int            CW         = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(MAX_WAIT);

    logic [CW-1:0] r_starve_cnt;
    logic          w_block;
    logic          w_gnt0;
    logic          w_gnt1;
    tag_t          w_issue_tag;
    tag_t          w_tail;

    // Grants are gated by reset as well so ready drops the instant RST_N falls.
    assign w_block    = flush || !RST_N;
    assign w_gnt1     = !w_block && req1_valid && (!req0_valid || (r_starve_cnt == STARVE_MAX));
    assign w_gnt0     = !w_block && req0_valid && !w_gnt1;
    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    // NOTE: every output gets its NOP value first, so no path through this
    // block leaves a signal unassigned and no latch is inferred.
    always_comb begin
        alu_imm    = NOP_IMM;
        alu_funct3 = FUNCT3_ADD;
        alu_funct7 = FUNCT7_ZERO;
        alu_rd     = '0;
        alu_wb     = 1'b0;
        alu_op1    = '0;
        alu_op2    = '0;
        if (w_gnt1) begin
            alu_imm    = req1_imm;
            alu_funct3 = req1_funct3;
            alu_funct7 = req1_funct7;
            alu_rd     = req1_rd;
            alu_wb     = req1_wb;
            alu_op1    = req1_op1;
            alu_op2    = req1_op2;
        end else if (w_gnt0) begin
            alu_imm    = req0_imm;
            alu_funct3 = req0_funct3;
            alu_funct7 = req0_funct7;
            alu_rd     = req0_rd;
            alu_wb     = req0_wb;
            alu_op1    = req0_op1;
            alu_op2    = req0_op2;
        end
    end

    // Flush freezes the count so a flush cannot rob req1 of accumulated credit.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_starve_cnt <= '0;
        end else if (!flush) begin
            if (!req1_valid || w_gnt1) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != STARVE_MAX) begin
                r_starve_cnt <= r_starve_cnt + CW'(1);
            end
        end
    end

    assign w_issue_tag = '{v: w_gnt0 | w_gnt1, owner: (w_gnt1 ? OWN_AUX : OWN_PIPE)};

    alu_tag_pipe #(
        .ALU_LAT (ALU_LAT)
    ) u_tag_pipe (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .i_flush (flush),
        .i_tag   (w_issue_tag),
        .o_tail  (w_tail)
    );

    assign rsp0_valid = w_tail.v && (w_tail.owner == OWN_PIPE);
    assign rsp1_valid = w_tail.v && (w_tail.owner == OWN_AUX);
    assign rsp0_res   = alu_res;
    assign rsp1_res   = alu_res;
    assign rsp0_rd    = alu_rd_o;
    assign rsp1_rd    = alu_rd_o;
    assign rsp0_wb    = alu_wb_en & rsp0_valid;
    assign rsp1_wb    = alu_wb_en & rsp1_valid;

endmodule

// File: tb/tb_alu_share_arb.sv
// Drives two arbiter instances (ALU_LAT 1 and 3) with shared directed stimulus
// and compares both against a queue-based model of issued operations.
module tb_alu_share_arb;
    import alu_share_arb_pkg::*;

    localparam int XLEN     = 64;
    localparam int MAX_WAIT = 4;
    localparam int LAT_A    = 1;
    localparam int LAT_B    = 3;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    logic flush = 1'b0;

    logic        req0_valid, req0_imm, req0_wb;
    logic [2:0]  req0_funct3;
    logic [6:0]  req0_funct7;
    logic [4:0]  req0_rd;
    logic [63:0] req0_op1, req0_op2;
    logic        req1_valid, req1_imm, req1_wb;
    logic [2:0]  req1_funct3;
    logic [6:0]  req1_funct7;
    logic [4:0]  req1_rd;
    logic [63:0] req1_op1, req1_op2;

    logic [1:0]  d_rdy0, d_rdy1, d_aimm, d_awb, d_v0, d_v1, d_wb0, d_wb1;
    logic [2:0]  d_af3  [2];
    logic [6:0]  d_af7  [2];
    logic [4:0]  d_ard  [2];
    logic [4:0]  d_rd0  [2];
    logic [4:0]  d_rd1  [2];
    logic [63:0] d_aop1 [2];
    logic [63:0] d_aop2 [2];
    logic [63:0] d_res0 [2];
    logic [63:0] d_res1 [2];

    logic [63:0] e_res [2];
    logic [4:0]  e_rd  [2];
    logic [1:0]  e_wb;
    logic [63:0] p_res [2][3];
    logic [4:0]  p_rd  [2][3];
    logic        p_wb  [2][3];

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    alu_share_arb #(.ALU_LAT(LAT_A), .XLEN(XLEN), .MAX_WAIT(MAX_WAIT)) u_dut_a (
        .CLK(CLK), .RST_N(RST_N), .flush(flush),
        .req0_valid(req0_valid), .req0_ready(d_rdy0[0]), .req0_imm(req0_imm),
        .req0_funct3(req0_funct3), .req0_funct7(req0_funct7), .req0_rd(req0_rd),
        .req0_wb(req0_wb), .req0_op1(req0_op1), .req0_op2(req0_op2),
        .req1_valid(req1_valid), .req1_ready(d_rdy1[0]), .req1_imm(req1_imm),
        .req1_funct3(req1_funct3), .req1_funct7(req1_funct7), .req1_rd(req1_rd),
        .req1_wb(req1_wb), .req1_op1(req1_op1), .req1_op2(req1_op2),
        .alu_imm(d_aimm[0]), .alu_funct3(d_af3[0]), .alu_funct7(d_af7[0]),
        .alu_rd(d_ard[0]), .alu_wb(d_awb[0]), .alu_op1(d_aop1[0]), .alu_op2(d_aop2[0]),
        .alu_res(e_res[0]), .alu_rd_o(e_rd[0]), .alu_wb_en(e_wb[0]),
        .rsp0_valid(d_v0[0]), .rsp0_res(d_res0[0]), .rsp0_rd(d_rd0[0]), .rsp0_wb(d_wb0[0]),
        .rsp1_valid(d_v1[0]), .rsp1_res(d_res1[0]), .rsp1_rd(d_rd1[0]), .rsp1_wb(d_wb1[0])
    );

    alu_share_arb #(.ALU_LAT(LAT_B), .XLEN(XLEN), .MAX_WAIT(MAX_WAIT)) u_dut_b (
        .CLK(CLK), .RST_N(RST_N), .flush(flush),
        .req0_valid(req0_valid), .req0_ready(d_rdy0[1]), .req0_imm(req0_imm),
        .req0_funct3(req0_funct3), .req0_funct7(req0_funct7), .req0_rd(req0_rd),
        .req0_wb(req0_wb), .req0_op1(req0_op1), .req0_op2(req0_op2),
        .req1_valid(req1_valid), .req1_ready(d_rdy1[1]), .req1_imm(req1_imm),
        .req1_funct3(req1_funct3), .req1_funct7(req1_funct7), .req1_rd(req1_rd),
        .req1_wb(req1_wb), .req1_op1(req1_op1), .req1_op2(req1_op2),
        .alu_imm(d_aimm[1]), .alu_funct3(d_af3[1]), .alu_funct7(d_af7[1]),
        .alu_rd(d_ard[1]), .alu_wb(d_awb[1]), .alu_op1(d_aop1[1]), .alu_op2(d_aop2[1]),
        .alu_res(e_res[1]), .alu_rd_o(e_rd[1]), .alu_wb_en(e_wb[1]),
        .rsp0_valid(d_v0[1]), .rsp0_res(d_res0[1]), .rsp0_rd(d_rd0[1]), .rsp0_wb(d_wb0[1]),
        .rsp1_valid(d_v1[1]), .rsp1_res(d_res1[1]), .rsp1_rd(d_rd1[1]), .rsp1_wb(d_wb1[1])
    );

    function automatic logic [63:0] alu_fn(input logic imm, input logic [2:0] f3,
                                           input logic [6:0] f7, input logic [63:0] a,
                                           input logic [63:0] b);
        case (f3)
            3'b000:  return (f7[5] && !imm) ? a - b : a + b;
            3'b100:  return a ^ b;
            3'b110:  return a | b;
            3'b111:  return a & b;
            default: return a + b;
        endcase
    endfunction

    // External ALU: a plain registered function with a LAT-deep result delay.
    always @(posedge CLK) begin
        for (int k = 0; k < 2; k++) begin
            p_res[k][0] <= alu_fn(d_aimm[k], d_af3[k], d_af7[k], d_aop1[k], d_aop2[k]);
            p_rd[k][0]  <= d_ard[k];
            p_wb[k][0]  <= d_awb[k];
            for (int s = 1; s < 3; s++) begin
                p_res[k][s] <= p_res[k][s-1];
                p_rd[k][s]  <= p_rd[k][s-1];
                p_wb[k][s]  <= p_wb[k][s-1];
            end
        end
    end

    assign e_res[0] = p_res[0][LAT_A-1];
    assign e_rd[0]  = p_rd[0][LAT_A-1];
    assign e_wb[0]  = p_wb[0][LAT_A-1];
    assign e_res[1] = p_res[1][LAT_B-1];
    assign e_rd[1]  = p_rd[1][LAT_B-1];
    assign e_wb[1]  = p_wb[1][LAT_B-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int          due;
        logic        owner;
        logic [63:0] res;
        logic [4:0]  rd;
        logic        wb;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_tmp[$];
    exp_t me, ce_a, ce_b;
    int   m_cyc    = 0;
    int   m_starve = 0;
    logic mg0, mg1, cg0, cg1, ch_a, ch_b;

    function automatic logic exp_gnt1();
        return RST_N && !flush && req1_valid && (!req0_valid || (m_starve == MAX_WAIT));
    endfunction

    function automatic logic exp_gnt0();
        return RST_N && !flush && req0_valid && !exp_gnt1();
    endfunction

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            q_a.delete();
            q_b.delete();
            m_starve = 0;
        end else begin
            mg1 = exp_gnt1();
            mg0 = exp_gnt0();
            m_cyc++;
            if (flush) begin
                q_tmp.delete();
                foreach (q_a[i]) if (q_a[i].due < m_cyc) q_tmp.push_back(q_a[i]);
                q_a = q_tmp;
                q_tmp.delete();
                foreach (q_b[i]) if (q_b[i].due < m_cyc) q_tmp.push_back(q_b[i]);
                q_b = q_tmp;
            end else begin
                if (mg0 || mg1) begin
                    me.owner = mg1;
                    me.res   = mg1 ? alu_fn(req1_imm, req1_funct3, req1_funct7, req1_op1, req1_op2)
                                   : alu_fn(req0_imm, req0_funct3, req0_funct7, req0_op1, req0_op2);
                    me.rd    = mg1 ? req1_rd : req0_rd;
                    me.wb    = mg1 ? req1_wb : req0_wb;
                    me.due   = m_cyc + LAT_A - 1;
                    q_a.push_back(me);
                    me.due   = m_cyc + LAT_B - 1;
                    q_b.push_back(me);
                end
                if (!req1_valid || mg1) m_starve = 0;
                else if (m_starve < MAX_WAIT) m_starve++;
            end
        end
    end

    task automatic cmp_rsp(input int k, input logic has, input exp_t e);
        string p;
        p = (k == 0) ? "L1" : "L3";
        check({p, " rsp0_valid"}, d_v0[k], has && !e.owner);
        check({p, " rsp1_valid"}, d_v1[k], has && e.owner);
        check({p, " rsp0_wb"}, d_wb0[k], (has && !e.owner) ? e.wb : 1'b0);
        check({p, " rsp1_wb"}, d_wb1[k], (has && e.owner) ? e.wb : 1'b0);
        if (has && !e.owner) begin
            check({p, " rsp0_res"}, d_res0[k], e.res);
            check({p, " rsp0_rd"}, d_rd0[k], e.rd);
        end
        if (has && e.owner) begin
            check({p, " rsp1_res"}, d_res1[k], e.res);
            check({p, " rsp1_rd"}, d_rd1[k], e.rd);
        end
    endtask

    // Per-cycle comparison on the falling edge, away from the active edge.
    always @(negedge CLK) begin
        logic [16:0] ef;
        logic [63:0] eo1, eo2;
        cg1 = exp_gnt1();
        cg0 = exp_gnt0();
        if (cg1) begin
            ef = {req1_imm, req1_funct3, req1_funct7, req1_rd, req1_wb};
            eo1 = req1_op1; eo2 = req1_op2;
        end else if (cg0) begin
            ef = {req0_imm, req0_funct3, req0_funct7, req0_rd, req0_wb};
            eo1 = req0_op1; eo2 = req0_op2;
        end else begin
            ef = {1'b1, 3'b000, 7'b0, 5'd0, 1'b0};
            eo1 = '0; eo2 = '0;
        end
        for (int k = 0; k < 2; k++) begin
            check($sformatf("L%0d req0_ready", k * 2 + 1), d_rdy0[k], cg0);
            check($sformatf("L%0d req1_ready", k * 2 + 1), d_rdy1[k], cg1);
            check($sformatf("L%0d alu_fields", k * 2 + 1),
                  {d_aimm[k], d_af3[k], d_af7[k], d_ard[k], d_awb[k]}, ef);
            check($sformatf("L%0d alu_op1", k * 2 + 1), d_aop1[k], eo1);
            check($sformatf("L%0d alu_op2", k * 2 + 1), d_aop2[k], eo2);
        end
        ce_a = '{default: '0};
        ce_b = '{default: '0};
        ch_a = (q_a.size() > 0) && (q_a[0].due == m_cyc);
        ch_b = (q_b.size() > 0) && (q_b[0].due == m_cyc);
        if (ch_a) ce_a = q_a.pop_front();
        if (ch_b) ce_b = q_b.pop_front();
        cmp_rsp(0, ch_a, ce_a);
        cmp_rsp(1, ch_b, ce_b);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input int n, input logic v, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] rd, input logic wb, input logic [63:0] a,
                         input logic [63:0] b);
        if (n == 0) begin
            req0_valid = v; req0_funct3 = f3; req0_funct7 = f7;
            req0_rd = rd; req0_wb = wb; req0_op1 = a; req0_op2 = b;
        end else begin
            req1_valid = v; req1_funct3 = f3; req1_funct7 = f7;
            req1_rd = rd; req1_wb = wb; req1_op1 = a; req1_op2 = b;
        end
    endtask

    logic [9:0] g1_hist;
    logic [5:0] v0_hist, v1_hist;
    logic [4:0] rd_hist [6];
    logic       a0;
    int         nv;

    task automatic sample_b(input int j);
        @(negedge CLK);
        v0_hist[j] = d_v0[1];
        v1_hist[j] = d_v1[1];
        rd_hist[j] = d_v0[1] ? d_rd0[1] : d_rd1[1];
    endtask

    initial begin
        req0_imm = 1'b0;
        req1_imm = 1'b0;
        drive(0, 0, 3'b0, 7'b0, 5'd0, 0, 64'd0, 64'd0);
        drive(1, 0, 3'b0, 7'b0, 5'd0, 0, 64'd0, 64'd0);
        repeat (2) tick();
        RST_N = 1'b1;
        repeat (2) tick();

        // req1 alone: same-cycle grant, result the next cycle
        drive(1, 1, 3'b000, 7'b0, 5'd4, 1, 64'd5, 64'd3);
        @(negedge CLK);
        check("t1 req1_ready", d_rdy1[0], 1'b1);
        check("t1 req0_ready", d_rdy0[0], 1'b0);
        tick();
        req1_valid = 1'b0;
        check("t1 rsp1_valid", d_v1[0], 1'b1);
        check("t1 rsp1_res", d_res1[0], 64'd8);
        check("t1 rsp1_rd", d_rd1[0], 64'd4);
        check("t1 rsp0_valid", d_v0[0], 1'b0);
        repeat (4) tick();

        // both valid continuously: four req0 grants, then a forced req1 grant
        drive(0, 1, 3'b000, 7'b0, 5'd10, 1, 64'd100, 64'd1);
        drive(1, 1, 3'b100, 7'b0, 5'd20, 1, 64'hF0, 64'h0F);
        g1_hist = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            g1_hist[i] = d_rdy1[0];
            a0 = d_rdy0[0];
            tick();
            if (i == 3) check("t2 starve at max", 64'(u_dut_a.r_starve_cnt), 64'd4);
            if (i == 4) check("t2 starve cleared", 64'(u_dut_a.r_starve_cnt), 64'd0);
            if (a0) req0_op1 = req0_op1 + 64'd1;
            if (g1_hist[i]) req1_op1 = req1_op1 + 64'h100;
        end
        check("t2 req1 grant pattern", g1_hist, 10'h210);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (5) tick();

        // req0 accepted, then flush the following cycle
        drive(0, 1, 3'b000, 7'b0100000, 5'd7, 1, 64'd10, 64'd3);
        @(negedge CLK);
        check("t3 req0_ready", d_rdy0[0], 1'b1);
        tick();
        flush = 1'b1;
        drive(0, 1, 3'b000, 7'b0, 5'd8, 1, 64'd20, 64'd4);
        @(negedge CLK);
        check("t3 flush blocks grant", {d_rdy0[1], d_rdy0[0]}, 2'b00);
        tick();
        flush = 1'b0;
        check("t3 L3 killed rsp0", d_v0[1], 1'b0);
        @(negedge CLK);
        check("t3 held op granted", d_rdy0[0], 1'b1);
        tick();
        req0_valid = 1'b0;
        check("t3 L3 still no rsp0", d_v0[1], 1'b0);
        repeat (5) tick();

        // alternating back-to-back issues on the 3-cycle ALU
        drive(0, 1, 3'b110, 7'b0, 5'd1, 1, 64'h30, 64'h0C);
        tick();
        drive(0, 0, 3'b000, 7'b0, 5'd0, 0, 64'd0, 64'd0);
        drive(1, 1, 3'b111, 7'b0, 5'd2, 0, 64'hFF, 64'h3C);
        sample_b(0);
        tick();
        drive(1, 0, 3'b000, 7'b0, 5'd0, 0, 64'd0, 64'd0);
        drive(0, 1, 3'b000, 7'b0, 5'd3, 1, 64'd40, 64'd2);
        sample_b(1);
        tick();
        req0_valid = 1'b0;
        for (int j = 2; j < 6; j++) begin
            sample_b(j);
            tick();
        end
        check("t4 rsp0 timing", v0_hist, 6'b010100);
        check("t4 rsp1 timing", v1_hist, 6'b001000);
        check("t4 rd first", rd_hist[2], 5'd1);
        check("t4 rd second", rd_hist[3], 5'd2);
        check("t4 rd third", rd_hist[4], 5'd3);
        repeat (3) tick();

        // idle: NOP issued, no responses
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check("t6 nop funct3", d_af3[0], 3'b000);
            check("t6 nop imm", d_aimm[0], 1'b1);
            check("t6 nop wb", d_awb[0], 1'b0);
            nv += int'(d_v0[0] | d_v1[0] | d_v0[1] | d_v1[1]);
            tick();
        end
        check("t6 idle responses", nv, 0);

        // reset while tags are in flight
        drive(0, 1, 3'b000, 7'b0, 5'd9, 1, 64'd7, 64'd7);
        tick();
        drive(0, 1, 3'b000, 7'b0, 5'd11, 1, 64'd1, 64'd1);
        check("t5 rsp0 before reset", d_v0[0], 1'b1);
        check("t5 ready before reset", d_rdy0[0], 1'b1);
        #1;
        RST_N = 1'b0;
        #1;
        check("t5 rsp0 in reset", {d_v0[1], d_v0[0]}, 2'b00);
        check("t5 ready in reset", {d_rdy0[1], d_rdy0[0]}, 2'b00);
        check("t5 alu imm in reset", d_aimm[0], 1'b1);
        check("t5 alu op1 in reset", d_aop1[0], 64'd0);
        req0_valid = 1'b0;
        repeat (2) tick();
        drive(1, 1, 3'b000, 7'b0, 5'd4, 1, 64'd5, 64'd3);
        RST_N = 1'b1;
        @(negedge CLK);
        check("t5 first grant after reset", d_rdy1[0], 1'b1);
        tick();
        req1_valid = 1'b0;
        check("t5 rsp1_valid", d_v1[0], 1'b1);
        check("t5 rsp1_res", d_res1[0], 64'd8);
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares the single registered ALU stage between two requesters: req0 is the integer pipeline issue path; req1 is a secondary unit such as address generation.
- Per cycle, it grants at most one requester, muxes that requester's operands into the ALU, and tags the operation.
- It routes the ALU result back to the owner after the ALU latency.
- req0 has fixed priority, but a starvation counter guarantees req1 forward progress.

Parameters:
ALU_LAT, 1, ALU result latency in cycles (>=1); depth of tag pipeline
XLEN, 64, operand/result width
MAX_WAIT, 4, consecutive blocked cycles of req1 before it is forced a grant (>=1)

Ports:
CLK  input  1  clock, all state on rising edge
RST_N  input  1  asynchronous active-low reset
flush  input  1  kill all in-flight ALU ops; block grants this cycle
reqN_valid  input  1  (N=0,1) requester N presents an op
reqN_ready  output  1  (N=0,1) grant; op accepted on valid&&ready at CLK edge
reqN_imm, reqN_funct3[3], reqN_funct7[7], reqN_rd[5], reqN_wb[1]  input  -  (N=0,1) op fields, stable while valid&&!ready
reqN_op1, reqN_op2  input  XLEN  (N=0,1) operands
alu_imm, alu_funct3[3], alu_funct7[7], alu_rd[5], alu_wb[1]  output  -  fields to ALU
alu_op1, alu_op2  output  XLEN  operands to ALU
alu_res  input  XLEN  ALU result, valid ALU_LAT cycles after issue
alu_rd_o, alu_wb_en  input  5/1  ALU-forwarded rd and write-back enable
rspN_valid  output  1  (N=0,1) result for requester N this cycle
rspN_res  output  XLEN  (N=0,1) = alu_res
rspN_rd, rspN_wb  output  5/1  (N=0,1) = alu_rd_o, alu_wb_en & rspN_valid

Behaviour:
- Grant is combinational in the cycle of valid: gnt1 = req1_valid && (!req0_valid || starve_cnt==MAX_WAIT); gnt0 = req0_valid && !gnt1. Both are forced 0 when flush or !RST_N.
- reqN_ready = gntN. Requesters must hold valid and fields until ready.
- ALU inputs are driven from the granted requester.
- With no grant, the ALU is driven with a NOP: funct3=000, imm=1, op1=op2=0, rd=0, wb=0.
- Tag pipeline: ALU_LAT stages of {v, owner}. Stage0 <= {gnt0|gnt1, gnt1}, and each stage shifts each cycle.
- rspN_valid = tail.v && tail.owner==N. This gives exactly ALU_LAT cycles from the accept edge to rsp valid; with ALU_LAT=1 the response is in the cycle after accept.
- Responses have no backpressure; the requester must consume them in the valid cycle.
- starve_cnt (width clog2(MAX_WAIT+1)):
  - +1 when req1_valid && !gnt1 && !flush, saturating at MAX_WAIT.
  - Cleared to 0 on gnt1 or when req1_valid is low.
  - Held on flush.
- Forced req1 grant: req0 sees ready=0 for that cycle and its op waits; there is no loss.
- flush:
  - All tag valids are cleared at the edge, including the op being issued in that cycle (none is issued, since grants are blocked).
  - rspN_valid is 0 from the next cycle until new issues age through.
  - The ALU still computes NOP/killed ops, and their results are ignored.
- Reset (async assert, sync deassert is the requester's concern):
  - Tag valids=0 and starve_cnt=0.
  - rspN_valid=0, reqN_ready=0, ALU fields = NOP.
  - Reset mid-operation discards in-flight ops with no response.
- Both requesters idle: NOP issued and no tag valid set.
- Back-to-back: one grant per cycle, so full throughput of 1 op/cycle is sustained.

Decomposition:
- Shared package: NOP field constants (FUNCT3_ADD=3'b000, FUNCT7_ZERO), owner encoding (OWN_PIPE=0, OWN_AUX=1), and the tag struct {v, owner}.
- One natural sub-module: alu_tag_pipe (ALU_LAT-deep valid/owner shift register with synchronous flush and async reset).
- Grant logic and the starvation counter stay in the top.

Test Plan:
1. Only req1_valid with op1=5, op2=3, funct3=000 -> req1_ready=1 same cycle; next cycle rsp1_valid=1, rsp1_res=8, rsp0_valid=0.
2. Both valid continuously, MAX_WAIT=4 -> req0 granted 4 cycles, req1 granted in the 5th cycle, and the pattern repeats; starve_cnt returns to 0 after each req1 grant.
3. req0 accepted (funct7=0100000, op1=10, op2=3) then flush asserted in the next cycle -> rsp0_valid stays 0 and no grant occurs in the flush cycle.
4. ALU_LAT=3 with 3 back-to-back alternating issues req0, req1, req0 -> rsp valid in the order 0, 1, 0, each 3 cycles after its accept; rd values match.
5. RST_N dropped while tags are valid -> rsp*_valid=0 and ready=0 immediately (asynchronously); after release, the first grant behaves as scenario 1.
6. Neither valid -> alu_funct3=000, alu_imm=1, alu_wb=0, and no rsp_valid for 10 cycles.
